// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment encoding and the
// hex-to-segment decode.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Active-high segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with hex decode, per-digit dp/enable, leading-zero
// blanking, PWM brightness and a frame-synchronous shadow register.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 262144,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  input  logic                    clr,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_o
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;

  logic pre_tc, frame_start;

  assign pre_tc      = (pre_cnt == PRE_TC);
  assign frame_start = pre_tc && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
    end
  end

  // Display only follows the shadow at a frame boundary (or clr), so a scan never tears.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (clr || frame_start) begin
      disp_val <= shadow_val;
      disp_dp  <= shadow_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
      frame_o <= 1'b0;
    end else if (clr) begin
      pre_cnt <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
      frame_o <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      frame_o <= frame_start;
      if (pre_tc) begin
        pre_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  upper_zero;

  // Walk from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz && (i != 0) && upper_zero && !disp_dp[i];
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_en, cur_blank, lit;
  logic [NUM_DIGITS-1:0] sel, an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_en    = digit_en[i];
        cur_blank = lz_mask[i];
        sel[i]    = 1'b1;
      end
    end
    lit     = cur_en && (pwm_cnt < brightness) && !cur_blank;
    seg_nxt = cur_blank ? SEG_OFF : hex_to_seg(cur_nib);
    an_nxt  = lit ? sel : '0;
    dp_nxt  = lit && cur_dp;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      a_to_g <= {7{POL}};
      an     <= {NUM_DIGITS{POL}};
      dp     <= POL;
    end else begin
      a_to_g <= seg_nxt ^ {7{POL}};
      an     <= an_nxt ^ {NUM_DIGITS{POL}};
      dp     <= dp_nxt ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-cycle slots, 2-bit PWM, active-low drive.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;

  logic          clk;
  logic          rst_ni;
  logic [15:0]   value;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] digit_en;
  logic          blank_lz;
  logic [1:0]    brightness;
  logic          load;
  logic          clr;
  logic [6:0]    a_to_g;
  logic [ND-1:0] an;
  logic          dp;
  logic          frame_o;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (4),
    .BRIGHT_W  (2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .blank_lz  (blank_lz),
    .brightness(brightness),
    .load      (load),
    .clr       (clr),
    .a_to_g    (a_to_g),
    .an        (an),
    .dp        (dp),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low segment patterns
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;  // edges since scan state was last all-zero

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int bad;
    int s;
    logic [3:0] exp_an;

    rst_ni = 1'b0; value = '0; dp_in = '0; digit_en = 4'b1111;
    blank_lz = 1'b0; brightness = 2'd3; load = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(a_to_g), 32'(SOFF));
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_frame", 32'(frame_o), 32'h0);

    // Basic scan: load goes to shadow, display follows at the first frame start
    rst_ni = 1'b1;
    cyc = 0;
    pulse_load(16'h12AF, 4'b0000);
    check("pre_frame_seg", 32'(a_to_g), 32'(S0));
    check("pre_frame_an", 32'(an), 32'hE);
    run_to(15);
    check("frame_not_yet", 32'(frame_o), 32'h0);
    run_to(16);
    check("frame_first", 32'(frame_o), 32'h1);
    run_to(17);
    check("frame_one_cycle", 32'(frame_o), 32'h0);
    check("scan_d0_an", 32'(an), 32'hE);
    check("scan_d0_seg", 32'(a_to_g), 32'(SF));
    check("scan_dp_off", 32'(dp), 32'h1);
    run_to(20);
    check("pwm_gate_an", 32'(an), 32'hF);
    run_to(21);
    check("scan_d1_an", 32'(an), 32'hD);
    check("scan_d1_seg", 32'(a_to_g), 32'(SA));
    run_to(25);
    check("scan_d2_an", 32'(an), 32'hB);
    check("scan_d2_seg", 32'(a_to_g), 32'(S2));
    run_to(29);
    check("scan_d3_an", 32'(an), 32'h7);
    check("scan_d3_seg", 32'(a_to_g), 32'(S1));
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if ($countones(~an) > 1) bad++;
    end
    check("anode_overlap", 32'(bad), 32'h0);

    // clr on a mid-frame terminal count (idx=1): restart at idx 0, display takes shadow
    pulse_load(16'h0007, 4'b0001);
    run_to(71);
    do_clr();
    check("clr_frame", 32'(frame_o), 32'h0);
    tick();
    check("clr_idx0_an", 32'(an), 32'hE);
    check("clr_disp_seg", 32'(a_to_g), 32'(S7));
    check("clr_dp", 32'(dp), 32'h0);

    // clr on the frame-start terminal count suppresses frame_o
    run_to(15);
    do_clr();
    check("clr_no_frame", 32'(frame_o), 32'h0);
    tick();
    check("clr_restart_an", 32'(an), 32'hE);

    // Leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'b0000);
    do_clr();
    tick();
    check("lz_d0_an", 32'(an), 32'hE);
    check("lz_d0_seg", 32'(a_to_g), 32'(S0));
    run_to(5);
    check("lz_d1_an", 32'(an), 32'hD);
    check("lz_d1_seg", 32'(a_to_g), 32'(S5));
    run_to(9);
    check("lz_d2_an", 32'(an), 32'hF);
    check("lz_d2_seg", 32'(a_to_g), 32'(SOFF));
    run_to(13);
    check("lz_d3_an", 32'(an), 32'hF);

    pulse_load(16'h0000, 4'b0000);
    do_clr();
    tick();
    check("lz0_d0_an", 32'(an), 32'hE);
    check("lz0_d0_seg", 32'(a_to_g), 32'(S0));
    run_to(5);
    check("lz0_d1_an", 32'(an), 32'hF);
    check("lz0_d1_seg", 32'(a_to_g), 32'(SOFF));

    pulse_load(16'h0000, 4'b0100);
    do_clr();
    run_to(9);
    check("lzdp_d2_an", 32'(an), 32'hB);
    check("lzdp_d2_seg", 32'(a_to_g), 32'(S0));
    check("lzdp_d2_dp", 32'(dp), 32'h0);
    run_to(13);
    check("lzdp_d3_an", 32'(an), 32'hF);
    blank_lz = 1'b0;

    // Tear-free load
    pulse_load(16'h5555, 4'b0000);
    do_clr();
    run_to(5);
    pulse_load(16'h1111, 4'b0000);
    run_to(13);
    check("tear_old_seg", 32'(a_to_g), 32'(S5));
    check("tear_old_an", 32'(an), 32'h7);
    run_to(15);
    pulse_load(16'h2222, 4'b0000);
    check("tear_frame", 32'(frame_o), 32'h1);
    run_to(17);
    check("tear_mid_d0", 32'(a_to_g), 32'(S1));
    run_to(29);
    check("tear_mid_d3", 32'(a_to_g), 32'(S1));
    run_to(33);
    check("tear_new_d0", 32'(a_to_g), 32'(S2));
    check("tear_new_an", 32'(an), 32'hE);

    // Brightness 0: always dark
    brightness = 2'd0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an !== 4'hF) bad++;
    end
    check("bright0_dark", 32'(bad), 32'h0);

    // Brightness 1: lit only in the pwm_cnt=0 cycle of each slot
    brightness = 2'd1;
    do_clr();
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      s = cyc - 1;
      exp_an = ((s % 4) == 0) ? ~(4'b0001 << ((s / 4) % 4)) : 4'hF;
      if (an !== exp_an) bad++;
    end
    check("bright1_gate", 32'(bad), 32'h0);

    // Digit 2 disabled
    brightness = 2'd3;
    digit_en = 4'b1011;
    do_clr();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an === 4'b1011) bad++;
      if (cyc == 9) check("en_d2_off", 32'(an), 32'hF);
    end
    check("en_never_d2", 32'(bad), 32'h0);
    digit_en = 4'b1111;

    // Asynchronous reset mid-frame
    do_clr();
    run_to(2);
    check("prersts_an", 32'(an), 32'hE);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(a_to_g), 32'(SOFF));
    check("async_rst_dp", 32'(dp), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
